// File: rtl/rgb_frame_sequencer.sv
// rgb_frame_sequencer: turns an unframed RGB pixel stream into SOP/EOP delimited
// frames of WIDTH x HEIGHT pixels. START, ABORT and CONTINUOUS are controlled
// through an Avalon-MM register slave, and completed frames are counted.
// Ports:
//   csi_clock_reset_clk / csi_clock_reset_reset_n : clock, async active-low reset
//   avs_ctrl_*    : MM slave (address 3b, read/write strobes, 32b data, read latency 1)
//   asi_sink1_*   : raw pixel sink (data/valid/ready)
//   aso_source1_* : framed pixel source (data/valid/ready/startofpacket/endofpacket)
module rgb_frame_sequencer #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned DIM_W  = 12
) (
   input  logic              csi_clock_reset_clk,
   input  logic              csi_clock_reset_reset_n,
   input  logic [2:0]        avs_ctrl_address,
   input  logic              avs_ctrl_read,
   input  logic              avs_ctrl_write,
   input  logic [31:0]       avs_ctrl_writedata,
   output logic [31:0]       avs_ctrl_readdata,
   input  logic [DATA_W-1:0] asi_sink1_data,
   input  logic              asi_sink1_valid,
   output logic              asi_sink1_ready,
   output logic [DATA_W-1:0] aso_source1_data,
   output logic              aso_source1_valid,
   input  logic              aso_source1_ready,
   output logic              aso_source1_startofpacket,
   output logic              aso_source1_endofpacket
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t              r_state;
   logic [DIM_W-1:0]    r_width, r_height, r_col, r_row;
   logic                r_cont, r_done, r_cfg_err, r_aborted;
   logic [CNT_W-1:0]    r_frame_cnt;
   logic [DATA_W-1:0]   r_data;
   logic                r_valid, r_sop, r_eop;
   logic [31:0]         r_readdata;

   logic w_wr_ctrl, w_wr_status, w_start, w_abort, w_cfg_ok, w_busy;
   logic w_sink_ready, w_accept, w_out_hs, w_col_last, w_row_last, w_eop_pix;
   logic w_done_set;
   logic [31:0] w_rdata;
   logic w_unused_wdata;

   // Register-write decode; ABORT in the same write suppresses START.
   assign w_wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == 3'd0);
   assign w_wr_status = avs_ctrl_write && (avs_ctrl_address == 3'd3);
   assign w_abort     = w_wr_ctrl && avs_ctrl_writedata[1];
   assign w_start     = w_wr_ctrl && avs_ctrl_writedata[0] && !avs_ctrl_writedata[1];
   assign w_cfg_ok    = (r_width != '0) && (r_height != '0);
   assign w_busy      = (r_state != S_IDLE);
   assign w_unused_wdata = &{1'b0, avs_ctrl_writedata[31:DIM_W]};

   // Stream handshakes and frame position.
   assign w_sink_ready = (r_state == S_RUN) && (!r_valid || aso_source1_ready);
   assign w_accept     = asi_sink1_valid && w_sink_ready;
   assign w_out_hs     = r_valid && aso_source1_ready;
   assign w_col_last   = (r_col == r_width - DIM_W'(1));
   assign w_row_last   = (r_row == r_height - DIM_W'(1));
   assign w_eop_pix    = w_col_last && w_row_last;
   // The EOP beat leaves in FLUSH only when the frame was not continued.
   assign w_done_set   = w_out_hs && r_eop && (r_state == S_FLUSH);

   // Sequencer FSM with column/row counters; counters wrap naturally at frame end.
   always_ff @(posedge csi_clock_reset_clk or negedge csi_clock_reset_reset_n) begin
      if (!csi_clock_reset_reset_n) begin
         r_state <= S_IDLE;
         r_col   <= '0;
         r_row   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start && w_cfg_ok) begin
                  r_state <= S_RUN;
                  r_col   <= '0;
                  r_row   <= '0;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_col_last) begin
                     r_col <= '0;
                     r_row <= w_row_last ? '0 : r_row + DIM_W'(1);
                  end else begin
                     r_col <= r_col + DIM_W'(1);
                  end
               end
               if (w_abort || (w_accept && w_eop_pix && !r_cont))
                  r_state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (!r_valid) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Output register: loads on accept, empties when consumed without a refill.
   always_ff @(posedge csi_clock_reset_clk or negedge csi_clock_reset_reset_n) begin
      if (!csi_clock_reset_reset_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
      end else if (w_accept) begin
         r_data  <= asi_sink1_data;
         r_valid <= 1'b1;
         r_sop   <= (r_col == '0) && (r_row == '0);
         r_eop   <= w_eop_pix;
      end else if (w_out_hs) begin
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
      end
   end

   // Configuration and status registers; sticky sets win over W1C.
   always_ff @(posedge csi_clock_reset_clk or negedge csi_clock_reset_reset_n) begin
      if (!csi_clock_reset_reset_n) begin
         r_width     <= '0;
         r_height    <= '0;
         r_cont      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_aborted   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (avs_ctrl_write && !w_busy && (avs_ctrl_address == 3'd1))
            r_width <= avs_ctrl_writedata[DIM_W-1:0];
         if (avs_ctrl_write && !w_busy && (avs_ctrl_address == 3'd2))
            r_height <= avs_ctrl_writedata[DIM_W-1:0];
         if (w_wr_ctrl)
            r_cont <= avs_ctrl_writedata[2];
         r_done    <= w_done_set ||
                      (r_done && !(w_wr_status && avs_ctrl_writedata[1]));
         r_cfg_err <= ((r_state == S_IDLE) && w_start && !w_cfg_ok) ||
                      (r_cfg_err && !(w_wr_status && avs_ctrl_writedata[2]));
         r_aborted <= ((r_state == S_RUN) && w_abort) ||
                      (r_aborted && !(w_wr_status && avs_ctrl_writedata[3]));
         if (w_out_hs && r_eop)
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
   end

   // Read mux; sampled before this cycle's write takes effect.
   always_comb begin
      w_rdata = '0;
      case (avs_ctrl_address)
         3'd1:    w_rdata = 32'(r_width);
         3'd2:    w_rdata = 32'(r_height);
         3'd3:    w_rdata = 32'({r_aborted, r_cfg_err, r_done, w_busy});
         3'd4:    w_rdata = 32'(r_frame_cnt);
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge csi_clock_reset_clk or negedge csi_clock_reset_reset_n) begin
      if (!csi_clock_reset_reset_n) r_readdata <= '0;
      else if (avs_ctrl_read)       r_readdata <= w_rdata;
   end

   assign avs_ctrl_readdata         = r_readdata;
   assign asi_sink1_ready           = w_sink_ready;
   assign aso_source1_data          = r_data;
   assign aso_source1_valid         = r_valid;
   assign aso_source1_startofpacket = r_sop;
   assign aso_source1_endofpacket   = r_eop;

endmodule

// File: tb/tb_rgb_frame_sequencer.sv
// Testbench for rgb_frame_sequencer: table of frame scenarios plus directed
// sequences for configuration errors, abort and asynchronous reset.
module tb_rgb_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  avs_address = '0;
   logic        avs_read = 1'b0, avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic [23:0] sink_data = '0;
   logic        sink_valid = 1'b0;
   logic        sink_ready;
   logic [23:0] src_data;
   logic        src_valid, src_sop, src_eop;
   logic        aso_ready = 1'b1;

   logic rdy_tog = 1'b0, rdy_lvl = 1'b1;
   logic mon_en = 1'b0;
   int   n_chk = 0, n_err = 0, cyc = 0;

   logic [25:0] got[$];
   int          first_seen[$], acc_cyc[$];
   logic        beat_new = 1'b1, stall_pend = 1'b0;
   logic [26:0] held;

   rgb_frame_sequencer dut (
      .csi_clock_reset_clk       (clk),
      .csi_clock_reset_reset_n   (rst_n),
      .avs_ctrl_address          (avs_address),
      .avs_ctrl_read             (avs_read),
      .avs_ctrl_write            (avs_write),
      .avs_ctrl_writedata        (avs_writedata),
      .avs_ctrl_readdata         (avs_readdata),
      .asi_sink1_data            (sink_data),
      .asi_sink1_valid           (sink_valid),
      .asi_sink1_ready           (sink_ready),
      .aso_source1_data          (src_data),
      .aso_source1_valid         (src_valid),
      .aso_source1_ready         (aso_ready),
      .aso_source1_startofpacket (src_sop),
      .aso_source1_endofpacket   (src_eop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Downstream ready: fixed level or toggling every cycle.
   always @(posedge clk) begin
      #1;
      if (rdy_tog) aso_ready = ~aso_ready;
      else         aso_ready = rdy_lvl;
   end

   // Monitor at the falling edge: handshakes, beat arrival cycle, stall stability.
   always @(negedge clk) begin
      cyc++;
      if (!mon_en) begin
         beat_new   = 1'b1;
         stall_pend = 1'b0;
      end else begin
         if (stall_pend)
            chk("hold_stable", 32'({src_valid, src_sop, src_eop, src_data}), 32'(held));
         if (sink_valid && sink_ready) acc_cyc.push_back(cyc);
         if (src_valid && beat_new) first_seen.push_back(cyc);
         if (src_valid && aso_ready) got.push_back({src_sop, src_eop, src_data});
         beat_new   = !src_valid || aso_ready;
         stall_pend = src_valid && !aso_ready;
         held       = {src_valid, src_sop, src_eop, src_data};
      end
   end

   task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(posedge clk); #1;
      avs_write = 1'b0;
   endtask

   task automatic mm_read(input logic [2:0] a, output logic [31:0] d);
      avs_address = a; avs_read = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      mon_en = 1'b0; rst_n = 1'b0;
      sink_valid = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
      rdy_tog = 1'b0; rdy_lvl = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(src_valid), 32'd0);
      chk("rst_sink_ready", 32'(sink_ready), 32'd0);
      chk("rst_sop_eop_data", 32'({src_sop, src_eop, src_data}), 32'd0);
      chk("rst_readdata", avs_readdata, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      got.delete(); first_seen.delete(); acc_cyc.delete();
   endtask

   // Offer n pixels base, base+1, ...; advance only on a handshake.
   task automatic run_pixels(input int n, input logic [23:0] base);
      int i = 0;
      int guard = 0;
      logic hs;
      while (i < n && guard < 1000) begin
         sink_data = base + 24'(i); sink_valid = 1'b1;
         @(negedge clk);
         hs = sink_valid && sink_ready;
         @(posedge clk); #1;
         if (hs) i++;
         guard++;
      end
      sink_valid = 1'b0;
      if (i != n) chk("src_timeout", 32'(i), 32'(n));
   endtask

   task automatic wait_beats(input int n);
      for (int g = 0; g < 200 && got.size() < n; g++) begin
         @(posedge clk); #1;
      end
      chk("beat_count", 32'(got.size()), 32'(n));
   endtask

   typedef struct {
      int          w;
      int          h;
      bit          cont;
      int          n;
      bit          tog;
      logic [23:0] base;
      int          exp_fc;
      logic [31:0] exp_status;
   } vec_t;

   vec_t vec[4];

   initial begin
      logic [31:0] rd;
      int fsz;

      vec[0] = '{w:4, h:2, cont:1'b0, n:8, tog:1'b0, base:24'h000001, exp_fc:1, exp_status:32'h2};
      vec[1] = '{w:4, h:2, cont:1'b0, n:8, tog:1'b1, base:24'h000010, exp_fc:1, exp_status:32'h2};
      vec[2] = '{w:3, h:1, cont:1'b1, n:9, tog:1'b0, base:24'h000100, exp_fc:3, exp_status:32'h1};
      vec[3] = '{w:1, h:1, cont:1'b0, n:1, tog:1'b0, base:24'hABCDEF, exp_fc:1, exp_status:32'h2};

      for (int s = 0; s < 4; s++) begin
         do_reset();
         rdy_tog = vec[s].tog;
         mon_en  = 1'b1;
         mm_write(3'd1, 32'(vec[s].w));
         mm_write(3'd2, 32'(vec[s].h));
         mm_write(3'd0, {29'd0, vec[s].cont, 2'b01});
         run_pixels(vec[s].n, vec[s].base);
         wait_beats(vec[s].n);
         fsz = vec[s].w * vec[s].h;
         for (int k = 0; k < got.size(); k++) begin
            chk($sformatf("s%0d_beat%0d_data", s, k), 32'(got[k][23:0]), 32'(vec[s].base + 24'(k)));
            chk($sformatf("s%0d_beat%0d_sop", s, k), 32'(got[k][25]), 32'((k % fsz) == 0));
            chk($sformatf("s%0d_beat%0d_eop", s, k), 32'(got[k][24]), 32'((k % fsz) == fsz - 1));
         end
         for (int k = 0; k < first_seen.size() && k < acc_cyc.size(); k++)
            chk($sformatf("s%0d_latency%0d", s, k), 32'(first_seen[k] - acc_cyc[k]), 32'd1);
         if (!vec[s].tog)
            for (int k = 1; k < acc_cyc.size(); k++)
               chk($sformatf("s%0d_no_bubble%0d", s, k), 32'(acc_cyc[k] - acc_cyc[0]), 32'(k));
         idle(3);
         mm_read(3'd3, rd); chk($sformatf("s%0d_status", s), rd, vec[s].exp_status);
         mm_read(3'd4, rd); chk($sformatf("s%0d_frame_cnt", s), rd, 32'(vec[s].exp_fc));
         chk($sformatf("s%0d_sink_ready", s), 32'(sink_ready), 32'(vec[s].cont));
         if (!vec[s].cont) begin
            mm_write(3'd3, 32'h2);
            mm_read(3'd3, rd); chk($sformatf("s%0d_done_w1c", s), rd, 32'h0);
         end
         mon_en = 1'b0;
      end

      // Configuration errors and register corner cases.
      do_reset();
      mm_write(3'd1, 32'd4);
      mm_write(3'd0, 32'h1);
      mm_read(3'd3, rd); chk("cfg_err_set", rd, 32'h4);
      chk("cfg_err_sink_ready", 32'(sink_ready), 32'd0);
      mm_write(3'd3, 32'h4);
      mm_read(3'd3, rd); chk("cfg_err_w1c", rd, 32'h0);
      mm_write(3'd2, 32'd2);
      mm_write(3'd0, 32'h3);
      mm_read(3'd3, rd); chk("start_abort_same_write", rd, 32'h0);
      mm_write(3'd0, 32'h1);
      mm_read(3'd3, rd); chk("busy_after_start", rd, 32'h1);
      mm_write(3'd1, 32'd7);
      mm_read(3'd1, rd); chk("width_locked_busy", rd, 32'd4);
      mm_write(3'd0, 32'h2);
      idle(3);
      mm_read(3'd3, rd); chk("abort_idle_status", rd, 32'h8);
      mm_read(3'd5, rd); chk("addr5_reads0", rd, 32'h0);
      avs_address = 3'd2; avs_writedata = 32'd9; avs_write = 1'b1; avs_read = 1'b1;
      @(posedge clk); #1;
      avs_write = 1'b0; avs_read = 1'b0;
      chk("rw_same_cycle_old", avs_readdata, 32'd2);
      mm_read(3'd2, rd); chk("rw_same_cycle_new", rd, 32'd9);

      // Abort after three pixels of a 4x4 frame, then restart.
      do_reset();
      mon_en = 1'b1;
      mm_write(3'd1, 32'd4);
      mm_write(3'd2, 32'd4);
      mm_write(3'd0, 32'h1);
      run_pixels(3, 24'h000200);
      mm_write(3'd0, 32'h2);
      idle(3);
      chk("abort_beats", 32'(got.size()), 32'd3);
      for (int k = 0; k < got.size(); k++) begin
         chk($sformatf("abort_beat%0d_data", k), 32'(got[k][23:0]), 32'h200 + 32'(k));
         chk($sformatf("abort_beat%0d_flags", k), 32'(got[k][25:24]), (k == 0) ? 32'h2 : 32'h0);
      end
      mm_read(3'd3, rd); chk("aborted_status", rd, 32'h8);
      chk("abort_sink_ready", 32'(sink_ready), 32'd0);
      mm_write(3'd0, 32'h1);
      run_pixels(1, 24'h000300);
      wait_beats(4);
      if (got.size() >= 4)
         chk("restart_sop", 32'(got[3]), {6'd0, 2'b10, 24'h000300});

      // Asynchronous reset with a stalled beat pending.
      do_reset();
      rdy_lvl = 1'b0;
      mm_write(3'd1, 32'd4);
      mm_write(3'd2, 32'd2);
      mm_write(3'd0, 32'h1);
      run_pixels(1, 24'h000400);
      chk("pre_reset_valid", 32'({src_valid, src_sop, src_data}), {7'd0, 2'b11, 24'h000400});
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid_drop", 32'(src_valid), 32'd0);
      chk("async_ready_drop", 32'(sink_ready), 32'd0);
      chk("async_data_clear", 32'({src_sop, src_eop, src_data}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      rdy_lvl = 1'b1;
      @(posedge clk); #1;
      mm_read(3'd1, rd); chk("post_rst_width", rd, 32'd0);
      mm_read(3'd2, rd); chk("post_rst_height", rd, 32'd0);
      mm_read(3'd3, rd); chk("post_rst_status", rd, 32'd0);
      mm_read(3'd4, rd); chk("post_rst_frame_cnt", rd, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rgb_frame_sequencer.md
# rgb_frame_sequencer

Frame sequencer and configuration controller placed in front of the RGB-to-grayscale Avalon-ST stage. It accepts an unframed 24-bit RGB pixel stream and gates it frame by frame under Avalon-MM register control. It inserts startofpacket/endofpacket from a programmed width × height and counts completed frames. The converter downstream then receives correctly delimited packets.

## Interface
- DATA_W, 24, pixel width (R[7:0], G[15:8], B[23:16]); passed through unmodified
- DIM_W, 12, width of the WIDTH/HEIGHT registers and of the column/row counters
- csi_clock_reset_clk  in  1  single clock; all logic rising-edge
- csi_clock_reset_reset_n  in  1  reset, asynchronous, active-low
- avs_ctrl_address  in  3  register index
- avs_ctrl_read / avs_ctrl_write  in  1  MM strobes; fixed read latency 1, no waitrequest
- avs_ctrl_writedata  in  32  write data
- avs_ctrl_readdata  out  32  registered read data
- asi_sink1_data  in  DATA_W  raw pixel
- asi_sink1_valid  in  1  pixel valid
- asi_sink1_ready  out  1  sequencer accepts pixel
- aso_source1_data  out  DATA_W  registered pixel
- aso_source1_valid  out  1  output beat valid
- aso_source1_ready  in  1  downstream accepts
- aso_source1_startofpacket / aso_source1_endofpacket  out  1  frame delimiters

## Operation
- Registers:
  - 0 CTRL (write-only, self-clearing): bit0 START, bit1 ABORT, bit2 CONTINUOUS (level, kept)
  - 1 WIDTH (DIM_W, r/w)
  - 2 HEIGHT (DIM_W, r/w)
  - 3 STATUS: bit0 BUSY (ro), bit1 DONE (sticky, write 1 to clear), bit2 CFG_ERR (sticky, W1C), bit3 ABORTED (sticky, W1C)
  - 4 FRAME_CNT (16 bit, ro, wraps 0xFFFF→0)
  - Addresses 5–7 read 0; writes to them are ignored.
- States:
  - IDLE: sink_ready=0; output register drains only.
  - RUN: pixels flow.
  - FLUSH: intake stopped; waits for output register empty, then IDLE.
- IDLE→RUN on START write when WIDTH≠0 and HEIGHT≠0. col and row are cleared on this transition.
- START with WIDTH=0 or HEIGHT=0: stay IDLE, set CFG_ERR.
- START while in RUN or FLUSH is ignored.
- WIDTH/HEIGHT writes while BUSY are ignored; the registers keep their old values.
- asi_sink1_ready = (state==RUN) && (!aso_source1_valid || aso_source1_ready).
- On accept (sink valid && ready):
  - Load data into the output register and set aso_source1_valid.
  - SOP = (col==0 && row==0).
  - EOP = (col==WIDTH-1 && row==HEIGHT-1).
  - col increments and wraps to 0 at WIDTH-1; row increments when col wraps.
- Accepting the EOP pixel:
  - If CONTINUOUS=1 and no ABORT: counters reset and the block stays in RUN with no bubble.
  - Otherwise: go to FLUSH.
- Output beat consumed (valid && ready, no new accept): aso_source1_valid clears.
- Handshaking the EOP beat downstream increments FRAME_CNT. When the block is not continuing, it also sets DONE.
- ABORT write in RUN:
  - Go to FLUSH; set ABORTED.
  - The pending output beat is still delivered unchanged; no EOP is synthesized.
  - ABORT in IDLE or FLUSH has no effect.
- START and ABORT in the same write: ABORT wins; START is ignored.
- A DONE-set event and a W1C on the same cycle: set wins.
- BUSY = (state != IDLE).

## Timing
- Reset values:
  - State IDLE; WIDTH=0, HEIGHT=0, CONTINUOUS=0, FRAME_CNT=0; all STATUS bits 0.
  - asi_sink1_ready=0, aso_source1_valid/SOP/EOP=0, aso_source1_data=0, avs_ctrl_readdata=0.
- Reset mid-frame: all outputs return to reset values immediately (async). The partial frame is discarded.
- Latency: sink accept at cycle N → beat on aso_source1_* at N+1.
- Sustained throughput is 1 pixel/cycle when aso_source1_ready=1.
- Backpressure: output data/SOP/EOP stay stable while valid && !ready.
- START write at cycle N → RUN at N+1; first sink_ready=1 at N+1.
- readdata is valid the cycle after avs_ctrl_read. A read and a write to the same register in the same cycle returns the old value.
- FLUSH→IDLE on the first cycle aso_source1_valid==0.

## Test plan
- Basic frame: WIDTH=4, HEIGHT=2, START, 8 pixels 0x000001..0x000008 with ready=1.
  - Expected: 8 beats, SOP on 0x000001 only, EOP on 0x000008 only.
  - Then FRAME_CNT=1, DONE=1, BUSY=0, sink_ready=0.
- Backpressure: same frame, downstream ready toggled 1010…
  - Expected: no beat lost or duplicated; data/SOP/EOP held stable while stalled.
  - Latency is 1 cycle when unstalled.
- Continuous: CONTINUOUS=1, WIDTH=3, HEIGHT=1, 9 pixels back-to-back.
  - Expected: SOP on beats 1, 4, 7; EOP on beats 3, 6, 9; no idle cycle between frames.
  - FRAME_CNT=3, BUSY=1 throughout.
- Config errors: START with HEIGHT=0 → CFG_ERR=1, state stays IDLE. Write WIDTH=7 while BUSY → read returns the old WIDTH.
- Abort: ABORT after pixel 3 of a 4×4 frame.
  - Expected: beats 1–3 delivered, no EOP, ABORTED=1, then IDLE.
  - A subsequent START produces SOP on the next pixel.
- Async reset asserted mid-frame with valid output pending.
  - Expected: valid/ready drop in the same cycle; all registers return to reset values.
